chip8_draw_ctrl: RTL

Sequencer for the CHIP-8 sprite-draw datapath. It executes DXYN (draw an N-row sprite) and 00E0 (clear screen) for the CPU. For DXYN it fetches sprite bytes from memory at I+row, presents one row at a time to the display XOR/collision datapath, and accumulates the collision flag. On completion it writes VF and pulses done.

---
 rtl/chip8_pkg.sv | 23 ++
 rtl/chip8_draw_ctrl.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/chip8_pkg.sv
// Shared types and constants for the CHIP-8 sprite-draw sequencer.
package chip8_pkg;

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_CLEAR  = 3'd1,
      S_VBWAIT = 3'd2,
      S_FETCH  = 3'd3,
      S_WAIT   = 3'd4,
      S_DRAW   = 3'd5,
      S_SAMPLE = 3'd6,
      S_FINISH = 3'd7
   } state_t;

   localparam int SCREEN_W = 64;
   localparam int SCREEN_H = 32;
   localparam int MAX_ROWS = 15;
   localparam int X_W      = $clog2(SCREEN_W);
   localparam int Y_W      = $clog2(SCREEN_H);

   localparam logic [3:0] VF_IDX = 4'hF;

endpackage

// File: rtl/chip8_draw_ctrl.sv
// DXYN / 00E0 sequencer: fetches sprite rows, drives the XOR datapath,
// accumulates collision and reports it through VF.
module chip8_draw_ctrl
   import chip8_pkg::*;
#(
   parameter int ADDR_W      = 12,
   parameter int MEM_LAT     = 1,
   parameter int VBLANK_WAIT = 0
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic              cls,
   input  logic [7:0]        vx,
   input  logic [7:0]        vy,
   input  logic [3:0]        n,
   input  logic [ADDR_W-1:0] i_reg,
   input  logic              vblank,
   output logic              mem_rd_en,
   output logic [ADDR_W-1:0] mem_addr,
   input  logic [7:0]        mem_rdata,
   output logic [5:0]        disp_x,
   output logic [4:0]        disp_y,
   output logic [3:0]        disp_row_index,
   output logic [7:0]        disp_sprite_data,
   output logic              disp_draw,
   input  logic              disp_collision,
   output logic              fb_clear,
   output logic              vf_we,
   output logic [7:0]        vf_out,
   output logic              busy,
   output logic              done
);

   state_t r_state;
   state_t w_next;

   logic [X_W-1:0]    r_x;
   logic [Y_W-1:0]    r_y;
   logic [3:0]        r_n;
   logic [ADDR_W-1:0] r_i;
   logic [3:0]        r_row;
   logic              r_sticky;
   logic              r_clr;
   logic [1:0]        r_wcnt;
   logic [X_W-1:0]    r_disp_x;
   logic [Y_W-1:0]    r_disp_y;
   logic [3:0]        r_disp_row;
   logic [7:0]        r_sprite;

   logic w_wlast;
   logic w_last_row;

   assign w_wlast    = (r_wcnt == 2'(MEM_LAT - 1));
   assign w_last_row = (r_row == r_n - 4'd1);

   always_ff @(posedge clk) begin
      if (reset) r_state <= S_IDLE;
      else       r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      unique case (r_state)
         S_IDLE: begin
            if (cls)
               w_next = S_CLEAR;
            else if (start) begin
               if (n == 4'd0)            w_next = S_FINISH;
               else if (VBLANK_WAIT != 0) w_next = S_VBWAIT;
               else                       w_next = S_FETCH;
            end
         end
         S_CLEAR:  w_next = S_FINISH;
         S_VBWAIT: if (vblank) w_next = S_FETCH;
         S_FETCH:  w_next = S_WAIT;
         S_WAIT:   if (w_wlast) w_next = S_DRAW;
         S_DRAW:   w_next = S_SAMPLE;
         S_SAMPLE: w_next = w_last_row ? S_FINISH : S_FETCH;
         S_FINISH: w_next = S_IDLE;
         default:  w_next = S_IDLE;
      endcase
   end

   // Display outputs are loaded in the last WAIT cycle so they hold between rows.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_x        <= '0;
         r_y        <= '0;
         r_n        <= '0;
         r_i        <= '0;
         r_row      <= '0;
         r_sticky   <= 1'b0;
         r_clr      <= 1'b0;
         r_wcnt     <= '0;
         r_disp_x   <= '0;
         r_disp_y   <= '0;
         r_disp_row <= '0;
         r_sprite   <= '0;
      end else begin
         unique case (r_state)
            S_IDLE: begin
               if (cls) begin
                  r_clr <= 1'b1;
               end else if (start) begin
                  r_clr    <= 1'b0;
                  r_x      <= X_W'(vx);
                  r_y      <= Y_W'(vy);
                  r_n      <= n;
                  r_i      <= i_reg;
                  r_row    <= '0;
                  r_sticky <= 1'b0;
               end
            end
            S_FETCH: r_wcnt <= '0;
            S_WAIT: begin
               r_wcnt <= r_wcnt + 2'd1;
               if (w_wlast) begin
                  r_sprite   <= mem_rdata;
                  r_disp_x   <= r_x;
                  r_disp_y   <= r_y;
                  r_disp_row <= r_row;
               end
            end
            S_SAMPLE: begin
               r_sticky <= r_sticky | disp_collision;
               if (!w_last_row) r_row <= r_row + 4'd1;
            end
            default: ;
         endcase
      end
   end

   always_comb begin
      mem_rd_en = 1'b0;
      disp_draw = 1'b0;
      fb_clear  = 1'b0;
      vf_we     = 1'b0;
      vf_out    = 8'h00;
      done      = 1'b0;
      busy      = (r_state != S_IDLE);
      unique case (r_state)
         S_FETCH: mem_rd_en = 1'b1;
         S_DRAW:  disp_draw = 1'b1;
         S_CLEAR: fb_clear  = 1'b1;
         S_FINISH: begin
            done = 1'b1;
            if (!r_clr) begin
               vf_we  = 1'b1;
               vf_out = {7'b0, r_sticky};
            end
         end
         default: ;
      endcase
   end

   assign mem_addr         = r_i + ADDR_W'(r_row);
   assign disp_x           = r_disp_x;
   assign disp_y           = r_disp_y;
   assign disp_row_index   = r_disp_row;
   assign disp_sprite_data = r_sprite;

endmodule
